// File: rtl/clock_period_meter_if.sv
// Measurement result bundle between the period meter and its consumer.
// The meter drives the result and status lines; the consumer returns the acknowledge.
interface clock_period_meter_if #(
  parameter int unsigned CNT_W = 16
);
  logic             meas_ack;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             overrun;
  logic             stalled;

  modport master (
    input  meas_ack,
    output period_out,
    output high_out,
    output meas_valid,
    output overrun,
    output stalled
  );

  modport slave (
    output meas_ack,
    input  period_out,
    input  high_out,
    input  meas_valid,
    input  overrun,
    input  stalled
  );
endinterface

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk12Mhz cycles,
// publishes results with a valid/ack handshake and flags a stalled source.
module clock_period_meter #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                 clk12Mhz,
  input  logic                 rst_n,
  input  logic                 sig_in,
  clock_period_meter_if.master meas
);

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  localparam logic [CNT_W-1:0] One        = CNT_W'(1);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             stalled_q, stalled_d;
  logic             rise;
  logic             publish;

  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    stalled_d = stalled_q;
    publish   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        hcnt_d = '0;
        if (rise) begin
          state_d   = StMeasure;
          cnt_d     = One;
          hcnt_d    = One;
          stalled_d = 1'b0;
        end
      end
      StMeasure: begin
        if (rise) begin
          publish   = 1'b1;
          cnt_d     = One;
          hcnt_d    = One;
          stalled_d = 1'b0;
        end else if (cnt_q == TimeoutCnt) begin
          stalled_d = 1'b1;
          state_d   = StIdle;
          cnt_d     = '0;
          hcnt_d    = '0;
        end else begin
          cnt_d  = cnt_q + One;
          hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, s2_q};
        end
      end
      default: state_d = StIdle;
    endcase

    // A fresh result always wins over a concurrent acknowledge.
    if (publish) begin
      period_d = cnt_q;
      high_d   = hcnt_q;
      valid_d  = 1'b1;
      if (valid_q && !meas.meas_ack) begin
        overrun_d = 1'b1;
      end else if (meas.meas_ack) begin
        overrun_d = 1'b0;
      end
    end else if (meas.meas_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk12Mhz) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= sig_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      stalled_q <= stalled_d;
    end
  end

  assign meas.period_out = period_q;
  assign meas.high_out   = high_q;
  assign meas.meas_valid = valid_q;
  assign meas.overrun    = overrun_q;
  assign meas.stalled    = stalled_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomised scoreboard bench for clock_period_meter: a sample-level reference model predicts
// measurements and status, and a monitor compares them with the DUT every cycle.
module tb_clock_period_meter;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 20;
  localparam int          Lat     = 2;  // sampled edge to registered result, in clocks

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } meas_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic sig_in = 1'b0;

  clock_period_meter_if #(.CNT_W(CNT_W)) mif ();

  clock_period_meter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk12Mhz(clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .meas    (mif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pubs  = 0;

  // Reference model state
  int               ec = 0;
  bit               prev = 1'b0;
  bit               measuring = 1'b0;
  int               last = 0;
  int               ones = 0;
  meas_t            pend_meas [int];
  bit               rise_pend [int];
  bit               stall_pend[int];
  meas_t            sb_q[$];
  logic             m_valid = 1'b0;
  logic             m_ov    = 1'b0;
  logic             m_st    = 1'b0;
  logic [CNT_W-1:0] m_period = '0;
  logic [CNT_W-1:0] m_high   = '0;

  int ack_mode = 0;
  int ack_wait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, ec, act, exp);
    end
  endtask

  // Model: derives periods from rising edges of the per-clock samples of sig_in.
  initial begin
    meas_t m;
    bit    v;
    forever begin
      @(posedge clk);
      ec = ec + 1;
      if (!rst_n) begin
        prev = 1'b0; measuring = 1'b0; ones = 0;
        pend_meas.delete(); rise_pend.delete(); stall_pend.delete(); sb_q.delete();
        m_valid = 1'b0; m_ov = 1'b0; m_st = 1'b0; m_period = '0; m_high = '0;
      end else begin
        if (rise_pend.exists(ec)) begin
          m_st = 1'b0;
          rise_pend.delete(ec);
        end
        if (stall_pend.exists(ec)) begin
          m_st = 1'b1;
          stall_pend.delete(ec);
        end
        if (pend_meas.exists(ec)) begin
          if (m_valid && !mif.meas_ack) m_ov = 1'b1;
          else if (mif.meas_ack)        m_ov = 1'b0;
          m_valid  = 1'b1;
          m_period = pend_meas[ec].period;
          m_high   = pend_meas[ec].high;
          sb_q.push_back(pend_meas[ec]);
          pend_meas.delete(ec);
        end else if (mif.meas_ack && m_valid) begin
          m_valid = 1'b0;
          m_ov    = 1'b0;
        end
        v = sig_in;
        if (!prev && v) begin
          rise_pend[ec+Lat] = 1'b1;
          if (measuring) begin
            m.period = CNT_W'(ec - last);
            m.high   = CNT_W'(ones);
            pend_meas[ec+Lat] = m;
          end
          last = ec; ones = 0; measuring = 1'b1;
        end else if (measuring && (ec - last) == TIMEOUT) begin
          stall_pend[ec+Lat] = 1'b1;
          measuring = 1'b0;
        end
        if (measuring && v) ones++;
        prev = v;
      end
    end
  end

  // Monitor: consumes published results and checks status every cycle.
  initial begin
    meas_t m;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        m = sb_q.pop_front();
        pubs++;
        check("pub_period", mif.period_out, m.period);
        check("pub_high",   mif.high_out,   m.high);
        check("pub_valid",  mif.meas_valid, 1);
      end
      check("meas_valid", mif.meas_valid, m_valid);
      check("overrun",    mif.overrun,    m_ov);
      check("stalled",    mif.stalled,    m_st);
      check("period_out", mif.period_out, m_period);
      check("high_out",   mif.high_out,   m_high);
    end
  end

  task automatic step(input bit v);
    @(posedge clk);
    #2;
    sig_in = v;
    case (ack_mode)
      0: mif.meas_ack = 1'b0;
      1: begin
        mif.meas_ack = 1'b0;
        if (mif.meas_valid) begin
          if (ack_wait == 0) mif.meas_ack = 1'b1;
          else ack_wait--;
        end else begin
          ack_wait = $urandom_range(0, 1);
        end
      end
      2: mif.meas_ack = pend_meas.exists(ec + 1);
      default: mif.meas_ack = ($urandom_range(0, 3) == 0);
    endcase
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    repeat (n) begin
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
    end
  endtask

  initial begin
    int pubs_before;
    mif.meas_ack = 1'b0;

    // Reset while the source toggles
    wave(3, 3, 1);
    check("rst_period",  mif.period_out, 0);
    check("rst_high",    mif.high_out,   0);
    check("rst_valid",   mif.meas_valid, 0);
    check("rst_overrun", mif.overrun,    0);
    check("rst_stalled", mif.stalled,    0);
    @(posedge clk); #2; rst_n = 1'b1;
    wave(3, 3, 3);
    check("first_valid",  mif.meas_valid, 1);
    check("first_period", mif.period_out, 6);
    check("first_high",   mif.high_out,   3);

    // Divider wave with prompt acknowledges
    ack_mode = 1;
    wave(3, 3, 100);
    check("ack_overrun", mif.overrun, 0);

    // Asymmetric wave with no acknowledge, then a single acknowledge
    ack_mode = 0;
    wave(2, 8, 4);
    check("asym_period",  mif.period_out, 10);
    check("asym_high",    mif.high_out,   2);
    check("asym_overrun", mif.overrun,    1);
    @(posedge clk); #2; mif.meas_ack = 1'b1;
    step(1'b0);
    check("asym_ack_valid",   mif.meas_valid, 0);
    check("asym_ack_overrun", mif.overrun,    0);
    wave(2, 8, 1);

    // Acknowledge coinciding with every publication
    ack_mode = 2;
    wave(3, 3, 6);
    check("coinc_valid",   mif.meas_valid, 1);
    check("coinc_overrun", mif.overrun,    0);

    // Stall and recovery
    ack_mode = 1;
    wave(3, 3, 3);
    repeat (TIMEOUT + 10) step(1'b0);
    check("stall_flag",   mif.stalled,    1);
    check("stall_period", mif.period_out, 6);
    wave(3, 3, 4);
    check("recover_stall", mif.stalled, 0);

    // Reset mid-period, then resume
    ack_mode = 0;
    wave(3, 3, 2);
    step(1'b1); step(1'b1);
    @(posedge clk); #2; rst_n = 1'b0;
    step(1'b1); step(1'b0); step(1'b0);
    check("mid_rst_valid", mif.meas_valid, 0);
    @(posedge clk); #2; rst_n = 1'b1;
    pubs_before = pubs;
    step(1'b0);
    wave(3, 3, 3);
    check("mid_rst_period", mif.period_out, 6);
    check("mid_rst_high",   mif.high_out,   3);
    check("mid_rst_pubs",   pubs - pubs_before, 2);

    // Randomised waves, including gaps long enough to stall
    for (int i = 0; i < 40; i++) begin
      ack_mode = $urandom_range(0, 3);
      wave($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 4));
    end
    ack_mode = 0;
    repeat (TIMEOUT + 5) step(1'b0);
    @(negedge clk);
    check("pubs_seen", (pubs > 150) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
